// File: rtl/accu_result_fifo.sv
// rtl/accu_result_fifo.sv - FWFT result FIFO after the 4-sample accumulator, with drop counting.
// Optional ACCU_AVG_EN: store the rounded average ((s_data+2)>>2) instead of the raw sum.
module accu_result_fifo #(
    parameter int DW    = 10,
    parameter int DEPTH = 4,
    parameter int CW    = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s_valid,
    input  logic [DW-1:0]              s_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DW-1:0]              m_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic [CW-1:0]              drop_cnt,
    input  logic                       clr_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;

    logic          full;
    logic          push;
    logic          pop;
    logic          drop;
    logic [DW-1:0] wdata;

    assign full    = (level_q == LW'(DEPTH));
    assign m_valid = (level_q != '0);
    assign pop     = m_valid && m_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push    = s_valid && (!full || pop);
    assign drop    = s_valid && full && !pop;

`ifdef ACCU_AVG_EN
    logic [DW-1:0] rnd_sum;
    assign rnd_sum = s_data + DW'(2);
    assign wdata   = rnd_sum >> 2;
`else
    assign wdata = s_data;
`endif

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

        if (push && !pop)      level_d = level_q + LW'(1);
        else if (pop && !push) level_d = level_q - LW'(1);

        // A drop in the same cycle as clr_ovf counts as the first event after the clear.
        if (drop) begin
            overflow_d = 1'b1;
            if (clr_ovf)          drop_cnt_d = CW'(1);
            else if (!(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + CW'(1);
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wdata;
    end

    assign m_data   = mem[rd_ptr_q];
    assign level    = level_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_accu_result_fifo.sv
// tb/tb_accu_result_fifo.sv - directed self-checking bench for accu_result_fifo.
module tb_accu_result_fifo;
    logic       clk;
    logic       rst_n;
    logic       s_valid;
    logic [9:0] s_data;
    logic       m_valid;
    logic       m_ready;
    logic [9:0] m_data;
    logic [2:0] level;
    logic       overflow;
    logic [7:0] drop_cnt;
    logic       clr_ovf;

    int total_cnt;
    int pass_cnt;

    accu_result_fifo #(.DW(10), .DEPTH(4), .CW(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .level    (level),
        .overflow (overflow),
        .drop_cnt (drop_cnt),
        .clr_ovf  (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        total_cnt++;
        if (m_valid !== 1'b0) $display("FAIL reset_m_valid: got %0b expected 0", m_valid);
        else pass_cnt++;
        total_cnt++;
        if (level !== 3'd0) $display("FAIL reset_level: got %0d expected 0", level);
        else pass_cnt++;
        total_cnt++;
        if (overflow !== 1'b0) $display("FAIL reset_overflow: got %0b expected 0", overflow);
        else pass_cnt++;
        total_cnt++;
        if (drop_cnt !== 8'd0) $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt);
        else pass_cnt++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = 10'd100;
        total_cnt++;
        if (m_valid !== 1'b0) $display("FAIL single_no_bypass: got %0b expected 0", m_valid);
        else pass_cnt++;
        step();
        s_valid = 1'b0;
        total_cnt++;
        if (m_valid !== 1'b1 || m_data !== 10'd100)
            $display("FAIL single_head: got valid=%0b data=%0d expected valid=1 data=100", m_valid, m_data);
        else pass_cnt++;
        total_cnt++;
        if (level !== 3'd1) $display("FAIL single_level1: got %0d expected 1", level);
        else pass_cnt++;
        step();
        total_cnt++;
        if (level !== 3'd0 || m_valid !== 1'b0)
            $display("FAIL single_popped: got level=%0d valid=%0b expected 0 0", level, m_valid);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        m_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            s_valid = 1'b1;
            s_data  = 10'(i);
            step();
        end
        s_valid = 1'b0;
        total_cnt++;
        if (level !== 3'd4 || overflow !== 1'b1 || drop_cnt !== 8'd1)
            $display("FAIL ovf_state: got level=%0d ovf=%0b cnt=%0d expected 4 1 1", level, overflow, drop_cnt);
        else pass_cnt++;
        m_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            total_cnt++;
            if (m_valid !== 1'b1 || m_data !== 10'(i))
                $display("FAIL ovf_drain%0d: got valid=%0b data=%0d expected 1 %0d", i, m_valid, m_data, i);
            else pass_cnt++;
            step();
        end
        total_cnt++;
        if (m_valid !== 1'b0 || level !== 3'd0)
            $display("FAIL ovf_empty: got valid=%0b level=%0d expected 0 0", m_valid, level);
        else pass_cnt++;
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        total_cnt++;
        if (overflow !== 1'b0 || drop_cnt !== 8'd0)
            $display("FAIL ovf_clear: got ovf=%0b cnt=%0d expected 0 0", overflow, drop_cnt);
        else pass_cnt++;
    endtask

    task automatic test_full_push_pop();
        m_ready = 1'b0;
        for (int i = 10; i <= 13; i++) begin
            s_valid = 1'b1;
            s_data  = 10'(i);
            step();
        end
        s_data  = 10'd14;
        m_ready = 1'b1;
        step();
        s_valid = 1'b0;
        total_cnt++;
        if (level !== 3'd4 || overflow !== 1'b0)
            $display("FAIL fullpp_state: got level=%0d ovf=%0b expected 4 0", level, overflow);
        else pass_cnt++;
        for (int i = 11; i <= 14; i++) begin
            total_cnt++;
            if (m_valid !== 1'b1 || m_data !== 10'(i))
                $display("FAIL fullpp_drain%0d: got valid=%0b data=%0d expected 1 %0d", i, m_valid, m_data, i);
            else pass_cnt++;
            step();
        end
        total_cnt++;
        if (level !== 3'd0) $display("FAIL fullpp_empty: got %0d expected 0", level);
        else pass_cnt++;
    endtask

    task automatic test_saturate();
        m_ready = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_data = 10'(20 + i);
            step();
        end
        s_data = 10'd99;
        repeat (300) step();
        total_cnt++;
        if (drop_cnt !== 8'd255 || overflow !== 1'b1)
            $display("FAIL sat_cnt: got cnt=%0d ovf=%0b expected 255 1", drop_cnt, overflow);
        else pass_cnt++;
        clr_ovf = 1'b1;
        step();
        total_cnt++;
        if (overflow !== 1'b1 || drop_cnt !== 8'd1)
            $display("FAIL sat_clr_drop: got ovf=%0b cnt=%0d expected 1 1", overflow, drop_cnt);
        else pass_cnt++;
        s_valid = 1'b0;
        step();
        clr_ovf = 1'b0;
        total_cnt++;
        if (overflow !== 1'b0 || drop_cnt !== 8'd0)
            $display("FAIL sat_clr_alone: got ovf=%0b cnt=%0d expected 0 0", overflow, drop_cnt);
        else pass_cnt++;
        total_cnt++;
        if (level !== 3'd4 || m_data !== 10'd20)
            $display("FAIL sat_contents: got level=%0d head=%0d expected 4 20", level, m_data);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_drain();
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        total_cnt++;
        if (level !== 3'd3 || m_data !== 10'd21)
            $display("FAIL mid_pre: got level=%0d head=%0d expected 3 21", level, m_data);
        else pass_cnt++;
        m_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (m_valid !== 1'b0 || level !== 3'd0)
            $display("FAIL mid_async: got valid=%0b level=%0d expected 0 0", m_valid, level);
        else pass_cnt++;
        @(negedge clk);
        rst_n   = 1'b1;
        m_ready = 1'b0;
        step();
        s_valid = 1'b1;
        s_data  = 10'd7;
        step();
        s_valid = 1'b0;
        total_cnt++;
        if (m_valid !== 1'b1 || m_data !== 10'd7 || level !== 3'd1)
            $display("FAIL mid_after: got valid=%0b data=%0d level=%0d expected 1 7 1", m_valid, m_data, level);
        else pass_cnt++;
        m_ready = 1'b1;
        step();
    endtask

    task automatic test_avg();
        logic [9:0] din [3];
        logic [9:0] exp [3];
        din[0] = 10'd1020; din[1] = 10'd1021; din[2] = 10'd6;
`ifdef ACCU_AVG_EN
        exp[0] = 10'd255;  exp[1] = 10'd255;  exp[2] = 10'd2;
`else
        exp[0] = 10'd1020; exp[1] = 10'd1021; exp[2] = 10'd6;
`endif
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_data  = din[i];
            step();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (m_valid !== 1'b1 || m_data !== exp[i])
                $display("FAIL avg_read%0d: got valid=%0b data=%0d expected 1 %0d", i, m_valid, m_data, exp[i]);
            else pass_cnt++;
            step();
        end
        total_cnt++;
        if (level !== 3'd0) $display("FAIL avg_empty: got %0d expected 0", level);
        else pass_cnt++;
    endtask

    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        clr_ovf = 1'b0;
        #1;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        test_single();
        test_overflow();
        test_full_push_pop();
        test_saturate();
        test_reset_mid_drain();
        test_avg();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
